// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin arbiter feeding one UART TX with ack/timeout handling; `define UART_SCHED_RETRY_EN enables retransmission
module uart_tx_scheduler #(
  parameter int REQUESTERS = 4,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT = 25000,
  parameter int MAX_RETRY = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [REQUESTERS-1:0]            req_valid,
  input  logic [REQUESTERS*DATA_WIDTH-1:0] req_data,
  output logic [REQUESTERS-1:0]            req_ready,
  output logic [REQUESTERS-1:0]            grant,
  input  logic                             tx_ready,
  output logic                             tx_start,
  output logic [DATA_WIDTH-1:0]            tx_data,
  input  logic                             tx_done,
  input  logic                             ack_valid,
  input  logic                             ack_ok,
  output logic                             done,
  output logic                             fail
);
  localparam int IW = $clog2(REQUESTERS);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, ARB, SEND, WAIT_TX, WAIT_ACK} state_t;
  state_t state;
  logic [IW-1:0] last_grant, gidx, pick, cand;
  logic [DATA_WIDTH-1:0] pick_data;
  logic found, tmo, retry_ev, can_retry;
  logic [TW-1:0] tmo_cnt;
`ifdef UART_SCHED_RETRY_EN
  localparam int RW = MAX_RETRY > 0 ? $clog2(MAX_RETRY + 1) : 1;
  logic [RW-1:0] retry_cnt;
  assign can_retry = retry_cnt < RW'(MAX_RETRY);
`else
  logic unused_max_retry;
  assign unused_max_retry = ^MAX_RETRY;
  assign can_retry = 1'b0;
`endif
  assign tmo = tmo_cnt == TW'(TIMEOUT - 1);
  // an ack arriving with the timeout takes priority over the timeout
  assign retry_ev = ack_valid ? !ack_ok : tmo;
  always_comb begin
    found = 1'b0;
    pick = '0;
    cand = '0;
    pick_data = '0;
    for (int k = REQUESTERS; k >= 1; k--) begin
      cand = IW'((int'(last_grant) + k) % REQUESTERS);
      if (req_valid[cand]) begin
        found = 1'b1;
        pick = cand;
      end
    end
    for (int k = 0; k < REQUESTERS; k++)
      if (pick == IW'(k)) pick_data = req_data[k*DATA_WIDTH +: DATA_WIDTH];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      last_grant <= IW'(REQUESTERS - 1);
      gidx <= '0;
      grant <= '0;
      req_ready <= '0;
      tx_start <= 1'b0;
      tx_data <= '0;
      done <= 1'b0;
      fail <= 1'b0;
      tmo_cnt <= '0;
`ifdef UART_SCHED_RETRY_EN
      retry_cnt <= '0;
`endif
    end else begin
      req_ready <= '0;
      tx_start <= 1'b0;
      done <= 1'b0;
      fail <= 1'b0;
      case (state)
        IDLE: state <= |req_valid ? ARB : IDLE;
        ARB: begin
          if (found) begin
            gidx <= pick;
            grant <= REQUESTERS'(1) << pick;
            req_ready <= REQUESTERS'(1) << pick;
            tx_data <= pick_data;
`ifdef UART_SCHED_RETRY_EN
            retry_cnt <= '0;
`endif
            state <= SEND;
          end else state <= IDLE;
        end
        SEND: begin
          if (tx_ready) begin
            tx_start <= 1'b1;
            state <= WAIT_TX;
          end
        end
        WAIT_TX: begin
          if (tx_done) begin
            tmo_cnt <= '0;
            state <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (ack_valid && ack_ok) begin
            done <= 1'b1;
            last_grant <= gidx;
            grant <= '0;
            state <= IDLE;
          end else if (retry_ev && can_retry) begin
`ifdef UART_SCHED_RETRY_EN
            retry_cnt <= retry_cnt + RW'(1);
`endif
            state <= SEND;
          end else if (retry_ev) begin
            fail <= 1'b1;
            last_grant <= gidx;
            grant <= '0;
            state <= IDLE;
          end else tmo_cnt <= tmo_cnt + TW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: scoreboard bench with a TX/ack responder model for uart_tx_scheduler
module tb_uart_tx_scheduler;
  localparam int N = 4, DW = 8, TMO = 100, MR = 2;
`ifdef UART_SCHED_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif
  localparam int NTRY = RETRY ? MR + 1 : 1;
  localparam int P_NONE = 0, P_ACK = 1, P_NAK = 2, P_EDGE = 3;
  logic clk = 1'b0, rst;
  logic [N-1:0] req_valid, req_ready, grant;
  logic [N*DW-1:0] req_data;
  logic tx_ready, tx_start, tx_done, ack_valid, ack_ok, done, fail;
  logic [DW-1:0] tx_data;
  int n_chk = 0, n_fail = 0, cyc = 0, n_gnt = 0, n_start = 0, n_res = 0;
  int exp_gnt[$];
  logic [DW-1:0] exp_tx[$];
  bit exp_res[$];
  int plan_q[$];
  uart_tx_scheduler #(.REQUESTERS(N), .DATA_WIDTH(DW), .TIMEOUT(TMO), .MAX_RETRY(MR)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .grant(grant), .tx_ready(tx_ready), .tx_start(tx_start), .tx_data(tx_data), .tx_done(tx_done),
    .ack_valid(ack_valid), .ack_ok(ack_ok), .done(done), .fail(fail)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic wait_for(input string tag, input int which, input int target, input int budget);
    for (int i = 0; i < budget && (which == 0 ? n_gnt : which == 1 ? n_start : n_res) < target; i++)
      @(negedge clk);
    check(tag, (which == 0 ? n_gnt : which == 1 ? n_start : n_res) >= target, 1);
  endtask
  task automatic check_quiet(input string tag);
    check({tag, "_grant"}, grant, 0);
    check({tag, "_req_ready"}, req_ready, 0);
    check({tag, "_tx_start"}, tx_start, 0);
    check({tag, "_tx_data"}, tx_data, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_fail"}, fail, 0);
  endtask
  always @(negedge clk) begin
    if (!rst) begin
      if (req_ready != 0) begin
        n_gnt++;
        if (exp_gnt.size() == 0) check("unexpected_req_ready", req_ready, 0);
        else begin
          check("req_ready", req_ready, 1 << exp_gnt[0]);
          check("grant", grant, 1 << exp_gnt[0]);
          void'(exp_gnt.pop_front());
        end
      end
      if (tx_start) begin
        n_start++;
        if (exp_tx.size() == 0) check("unexpected_tx_start", 1, 0);
        else check("tx_data", tx_data, exp_tx.pop_front());
      end
      if (done || fail) begin
        n_res++;
        check("grant_cleared", grant, 0);
        if (exp_res.size() == 0) check("unexpected_result", {done, fail}, 0);
        else check("result_done_fail", {done, fail}, exp_res.pop_front() ? 2 : 1);
      end
    end
  end
  initial begin
    int p;
    tx_done = 1'b0;
    ack_valid = 1'b0;
    ack_ok = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start && !rst) begin
        p = plan_q.size() > 0 ? plan_q.pop_front() : P_NONE;
        repeat (10) @(posedge clk);
        #1 tx_done = 1'b1;
        @(posedge clk);
        #1 tx_done = 1'b0;
        if (p == P_ACK || p == P_NAK) begin
          repeat (4) @(posedge clk);
          #1 ack_valid = 1'b1;
          ack_ok = p == P_ACK;
          @(posedge clk);
          #1 ack_valid = 1'b0;
        end else if (p == P_EDGE) begin
          repeat (TMO - 1) @(posedge clk);
          #1 ack_valid = 1'b1;
          ack_ok = 1'b1;
          @(posedge clk);
          #1 ack_valid = 1'b0;
        end
      end
    end
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got stuck expected finish");
    $fatal(1, "watchdog expired");
  end
  initial begin
    int s0, r0, td;
    bit got_fail;
    rst = 1'b1;
    req_valid = '0;
    req_data = '0;
    tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_quiet("reset");
    @(posedge clk);
    #1 rst = 1'b0;
    // single requester, ACKed
    @(posedge clk);
    #1 req_data[7:0] = 8'hCC;
    req_valid = 4'b0001;
    exp_gnt.push_back(0); exp_tx.push_back(8'hCC); exp_res.push_back(1'b1); plan_q.push_back(P_ACK);
    s0 = n_start;
    @(negedge clk);
    @(negedge clk);
    check("latency_1cyc", req_ready, 0);
    @(negedge clk);
    check("latency_2cyc", req_ready, 4'b0001);
    req_valid = '0;
    wait_for("single_done", 2, n_res + 1, 300);
    check("single_starts", n_start - s0, 1);
    // stray tx_done/ack while idle
    s0 = n_start;
    r0 = n_res;
    @(posedge clk);
    #1 tx_done = 1'b1; ack_valid = 1'b1; ack_ok = 1'b1;
    @(posedge clk);
    #1 tx_done = 1'b0; ack_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("idle_no_start", n_start, s0);
    check("idle_no_result", n_res, r0);
    check("idle_grant", grant, 0);
    // reset during WAIT_ACK
    @(posedge clk);
    #1 req_data[15:8] = 8'h3C;
    req_valid = 4'b0010;
    exp_gnt.push_back(1); exp_tx.push_back(8'h3C); plan_q.push_back(P_NONE);
    r0 = n_res;
    wait_for("abort_start", 1, n_start + 1, 100);
    req_valid = '0;
    repeat (40) @(negedge clk);
    rst = 1'b1;
    #1 check_quiet("abort_async");
    @(negedge clk);
    check_quiet("abort");
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_no_result", n_res, r0);
    // all four requesting: round robin from index 0
    @(posedge clk);
    #1 req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    req_valid = 4'b1111;
    foreach (exp_gnt[i]) check("queue_clean", 1, 0);
    for (int i = 0; i < 5; i++) begin
      exp_gnt.push_back(i % 4); exp_tx.push_back(8'h10 + 8'(i % 4)); exp_res.push_back(1'b1); plan_q.push_back(P_ACK);
    end
    r0 = n_res;
    wait_for("rr_grants", 0, n_gnt + 5, 2000);
    req_valid = '0;
    wait_for("rr_done", 2, r0 + 5, 500);
    // no ack at all: timeouts
    @(posedge clk);
    #1 req_data[23:16] = 8'h5A;
    req_valid = 4'b0100;
    exp_gnt.push_back(2); exp_res.push_back(1'b0);
    for (int i = 0; i < NTRY; i++) begin
      exp_tx.push_back(8'h5A); plan_q.push_back(P_NONE);
    end
    s0 = n_start;
    td = -1;
    got_fail = 1'b0;
    for (int i = 0; i < 1000 && !got_fail; i++) begin
      @(negedge clk);
      if (req_ready != 0) req_valid = '0;
      if (tx_done) td = cyc;
      if (tx_start && td >= 0) check("retry_gap", cyc - td, TMO + 2);
      if (fail) begin
        got_fail = 1'b1;
        check("fail_gap", cyc - td, TMO + 1);
      end
    end
    check("timeout_fail_seen", got_fail, 1);
    check("timeout_starts", n_start - s0, NTRY);
    // NAK then ACK
    @(posedge clk);
    #1 req_data[31:24] = 8'hA7;
    req_valid = 4'b1000;
    exp_gnt.push_back(3); exp_res.push_back(RETRY); plan_q.push_back(P_NAK);
    exp_tx.push_back(8'hA7);
    if (RETRY) begin
      exp_tx.push_back(8'hA7); plan_q.push_back(P_ACK);
    end
    s0 = n_start;
    wait_for("nak_grant", 0, n_gnt + 1, 50);
    req_valid = '0;
    wait_for("nak_result", 2, n_res + 1, 500);
    check("nak_starts", n_start - s0, RETRY ? 2 : 1);
    // ACK in the timeout cycle
    @(posedge clk);
    #1 req_data[7:0] = 8'hE1;
    req_valid = 4'b0001;
    exp_gnt.push_back(0); exp_tx.push_back(8'hE1); exp_res.push_back(1'b1); plan_q.push_back(P_EDGE);
    s0 = n_start;
    wait_for("edge_grant", 0, n_gnt + 1, 50);
    req_valid = '0;
    wait_for("edge_result", 2, n_res + 1, 500);
    repeat (20) @(negedge clk);
    check("edge_starts", n_start - s0, 1);
    check("sb_empty", exp_gnt.size() + exp_tx.size() + exp_res.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
